ex_cond_stage: RTL and testbench

//  Execute-stage back end. Consumes ALU result and flags, holds the architectural
//  Z/N flag register and evaluates each instruction's 4-bit condition field against it.

---
 rtl/cond_defs_pkg.sv | 33 +++
 rtl/ex_cond_stage_cond_check.sv | 34 +++
 rtl/ex_cond_stage.sv | 81 ++++++++
 tb/tb_ex_cond_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cond_defs_pkg.sv
// Shared definitions for the execute-stage condition logic: condition
// encodings, flag bit positions and the EX/MEM pipeline register layout.
package cond_defs;

  localparam int DATA_W = 4;
  localparam int RD_W   = 4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    MI = 4'd4,
    PL = 4'd5,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14
  } cond_e;

  // Field widths follow DATA_W / RD_W, so the top-level N and R must match them
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_write;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
  } exmem_t;

endpackage

// File: rtl/ex_cond_stage_cond_check.sv
// Combinational condition evaluator: decides whether a 4-bit condition code
// holds for the given {N,Z} flag pair. Unknown encodings never pass.
module cond_check
  import cond_defs::*;
(
  input  logic [3:0] cond_i,
  input  logic [1:0] flags_i,
  output logic       pass_o
);

  logic z_flag;
  logic n_flag;

  assign z_flag = flags_i[FLAG_Z];
  assign n_flag = flags_i[FLAG_N];

  // Decode the condition against the flags; anything not listed becomes a bubble
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      EQ:      pass_o = z_flag;
      NE:      pass_o = ~z_flag;
      MI:      pass_o = n_flag;
      PL:      pass_o = ~n_flag;
      GT:      pass_o = ~z_flag & ~n_flag;
      GE:      pass_o = ~n_flag;
      LT:      pass_o = n_flag;
      LE:      pass_o = z_flag | n_flag;
      AL:      pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_cond_stage.sv
// Execute-stage back end: holds the architectural Z/N flags, gates each
// instruction's side effects on its condition and registers the survivors
// into the EX/MEM pipeline register with flush/stall control.
module ex_cond_stage
  import cond_defs::*;
#(
  parameter int N = DATA_W,
  parameter int R = RD_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [3:0]   cond_i,
  input  logic         flag_write_i,
  input  logic         reg_write_i,
  input  logic         mem_write_i,
  input  logic         branch_i,
  input  logic [N-1:0] alu_result_i,
  input  logic [1:0]   alu_flags_i,
  input  logic [N-1:0] write_data_i,
  input  logic [R-1:0] rd_i,
  output logic         cond_pass_o,
  output logic         branch_take_o,
  output logic [1:0]   flags_o,
  output logic         valid_o,
  output logic         reg_write_o,
  output logic         mem_write_o,
  output logic [N-1:0] alu_result_o,
  output logic [N-1:0] write_data_o,
  output logic [R-1:0] rd_o
);

  logic [1:0] flags_q;
  exmem_t     exmem_q;
  logic       pass;

  // Conditions look only at the committed flag register, so a flag-setting
  // instruction naturally feeds the next one without a bypass path
  cond_check u_cond_check (
    .cond_i  (cond_i),
    .flags_i (flags_q),
    .pass_o  (cond_pass_o)
  );

  assign pass          = valid_i & cond_pass_o & ~flush_i;
  assign branch_take_o = valid_i & branch_i & cond_pass_o & ~flush_i;

  // Flag and EX/MEM registers: flush squashes control bits even under stall,
  // stall freezes everything, otherwise the gated instruction advances
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= 2'b00;
      exmem_q <= '0;
    end else if (flush_i) begin
      exmem_q.valid     <= 1'b0;
      exmem_q.reg_write <= 1'b0;
      exmem_q.mem_write <= 1'b0;
    end else if (!stall_i) begin
      exmem_q.valid     <= pass;
      exmem_q.reg_write <= pass & reg_write_i;
      exmem_q.mem_write <= pass & mem_write_i;
      exmem_q.result    <= alu_result_i;
      exmem_q.wdata     <= write_data_i;
      exmem_q.rd        <= rd_i;
      if (pass && flag_write_i) begin
        flags_q <= alu_flags_i;
      end
    end
  end

  assign flags_o      = flags_q;
  assign valid_o      = exmem_q.valid;
  assign reg_write_o  = exmem_q.reg_write;
  assign mem_write_o  = exmem_q.mem_write;
  assign alu_result_o = exmem_q.result;
  assign write_data_o = exmem_q.wdata;
  assign rd_o         = exmem_q.rd;

endmodule

// File: tb/tb_ex_cond_stage.sv
// Self-checking bench for ex_cond_stage: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the stage.
module tb_ex_cond_stage;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       stall_i, flush_i, valid_i;
  logic [3:0] cond_i;
  logic       flag_write_i, reg_write_i, mem_write_i, branch_i;
  logic [3:0] alu_result_i;
  logic [1:0] alu_flags_i;
  logic [3:0] write_data_i;
  logic [3:0] rd_i;
  logic       cond_pass_o, branch_take_o;
  logic [1:0] flags_o;
  logic       valid_o, reg_write_o, mem_write_o;
  logic [3:0] alu_result_o, write_data_o, rd_o;

  int error_count = 0;
  int check_count = 0;

  // Model of the architectural state seen at the EX/MEM boundary
  logic [1:0] m_flags;
  logic       m_valid, m_rw, m_mw;
  logic [3:0] m_res, m_wd, m_rd;

  // Legal condition codes, used to bias random stimulus toward real instructions
  logic [3:0] legal_codes [9] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};

  ex_cond_stage dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .valid_i       (valid_i),
    .cond_i        (cond_i),
    .flag_write_i  (flag_write_i),
    .reg_write_i   (reg_write_i),
    .mem_write_i   (mem_write_i),
    .branch_i      (branch_i),
    .alu_result_i  (alu_result_i),
    .alu_flags_i   (alu_flags_i),
    .write_data_i  (write_data_i),
    .rd_i          (rd_i),
    .cond_pass_o   (cond_pass_o),
    .branch_take_o (branch_take_o),
    .flags_o       (flags_o),
    .valid_o       (valid_o),
    .reg_write_o   (reg_write_o),
    .mem_write_o   (mem_write_o),
    .alu_result_o  (alu_result_o),
    .write_data_o  (write_data_o),
    .rd_o          (rd_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  // Architectural meaning of each condition mnemonic in terms of Z and N
  function automatic bit model_cond(input logic [3:0] c, input logic [1:0] f);
    bit z, n;
    z = f[0];
    n = f[1];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd4:    return n;
      4'd5:    return !n;
      4'd12:   return !z && !n;
      4'd10:   return !n;
      4'd11:   return n;
      4'd13:   return z || n;
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Count one comparison and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every registered output against the model
  task automatic check_regs(input string tag);
    checkOutput({tag, ".flags"},  32'(flags_o),      32'(m_flags));
    checkOutput({tag, ".valid"},  32'(valid_o),      32'(m_valid));
    checkOutput({tag, ".rw"},     32'(reg_write_o),  32'(m_rw));
    checkOutput({tag, ".mw"},     32'(mem_write_o),  32'(m_mw));
    checkOutput({tag, ".result"}, 32'(alu_result_o), 32'(m_res));
    checkOutput({tag, ".wdata"},  32'(write_data_o), 32'(m_wd));
    checkOutput({tag, ".rd"},     32'(rd_o),         32'(m_rd));
  endtask

  task automatic model_reset();
    m_flags = 2'b00;
    m_valid = 1'b0;
    m_rw    = 1'b0;
    m_mw    = 1'b0;
    m_res   = 4'h0;
    m_wd    = 4'h0;
    m_rd    = 4'h0;
  endtask

  // Drive one instruction slot (called 1 ns after a rising edge), check the
  // combinational outputs mid-cycle, then check the registers after the edge
  task automatic applyStimulus(input string tag,
                               input logic st, input logic fl, input logic vl,
                               input logic [3:0] cc, input logic fw, input logic rw,
                               input logic mw, input logic br, input logic [3:0] res,
                               input logic [1:0] af, input logic [3:0] wd,
                               input logic [3:0] rd);
    bit exp_pass, exp_cond;
    stall_i      = st;
    flush_i      = fl;
    valid_i      = vl;
    cond_i       = cc;
    flag_write_i = fw;
    reg_write_i  = rw;
    mem_write_i  = mw;
    branch_i     = br;
    alu_result_i = res;
    alu_flags_i  = af;
    write_data_i = wd;
    rd_i         = rd;
    #3;
    exp_cond = model_cond(cc, m_flags);
    exp_pass = vl && exp_cond && !fl;
    checkOutput({tag, ".cond_pass"}, 32'(cond_pass_o), 32'(exp_cond));
    checkOutput({tag, ".br_take"},   32'(branch_take_o), 32'(exp_pass && br));
    if (fl) begin
      m_valid = 1'b0;
      m_rw    = 1'b0;
      m_mw    = 1'b0;
    end else if (!st) begin
      m_valid = exp_pass;
      m_rw    = exp_pass && rw;
      m_mw    = exp_pass && mw;
      m_res   = res;
      m_wd    = wd;
      m_rd    = rd;
      if (exp_pass && fw) m_flags = af;
    end
    @(posedge clk_i);
    #1;
    check_regs(tag);
  endtask

  // Directed scenarios first, then a randomized run against the model
  initial begin
    logic [3:0] r_res;
    logic [3:0] r_cond;
    rst_ni = 1'b0;
    applyDefaults();
    model_reset();
    #2;
    check_regs("reset_init");
    #10;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Idle after reset: no instruction, nothing valid
    applyStimulus("idle", 0,0,0, 4'd14, 0,1,1,0, 4'h3, 2'b00, 4'h1, 4'h2);

    // Flag use: ADD sets Z, then EQ passes and NE fails
    applyStimulus("add_z",  0,0,1, 4'd14, 1,1,0,0, 4'h0, 2'b01, 4'h0, 4'h1);
    applyStimulus("eq_op",  0,0,1, 4'd0,  0,1,0,0, 4'h5, 2'b00, 4'h6, 4'h2);
    applyStimulus("ne_op",  0,0,1, 4'd1,  0,1,0,0, 4'h7, 2'b00, 4'h8, 4'h3);

    // Conditional flag write: clear flags, then LT flag-setter must not update
    applyStimulus("clr_fl", 0,0,1, 4'd14, 1,0,0,0, 4'h5, 2'b00, 4'h0, 4'h4);
    applyStimulus("lt_fw",  0,0,1, 4'd11, 1,1,0,0, 4'h9, 2'b10, 4'h0, 4'h5);

    // Stall: result A advances, then three stalled cycles with fresh inputs
    applyStimulus("adv_a",  0,0,1, 4'd14, 0,1,0,0, 4'hA, 2'b10, 4'hB, 4'h6);
    for (int i = 0; i < 3; i++)
      applyStimulus("stall", 1,0,1, 4'd14, 1,1,1,0, 4'(i + 1), 2'b01, 4'hC, 4'h7);
    applyStimulus("unstall", 0,0,1, 4'd14, 0,1,0,0, 4'h4, 2'b00, 4'hD, 4'h8);

    // Flush: AL store squashed, both alone and together with a stall
    applyStimulus("flush",    0,1,1, 4'd14, 1,0,1,1, 4'hE, 2'b10, 4'h1, 4'h9);
    applyStimulus("fl_stall", 1,1,1, 4'd14, 1,0,1,1, 4'hF, 2'b10, 4'h2, 4'hA);

    // Branch: flags=N, MI taken, PL not, undefined encoding never passes
    applyStimulus("set_n",  0,0,1, 4'd14, 1,0,0,0, 4'h8, 2'b10, 4'h0, 4'hB);
    applyStimulus("br_mi",  0,0,1, 4'd4,  0,0,0,1, 4'h0, 2'b00, 4'h0, 4'hC);
    applyStimulus("br_pl",  0,0,1, 4'd5,  0,0,0,1, 4'h0, 2'b00, 4'h0, 4'hD);
    applyStimulus("cond_f", 0,0,1, 4'hF,  0,1,0,1, 4'h0, 2'b00, 4'h0, 4'hE);

    // Asynchronous reset mid-stream drops the in-flight instruction
    applyStimulus("pre_rst", 0,0,1, 4'd14, 1,1,1,0, 4'h6, 2'b00, 4'h7, 4'hF);
    rst_ni = 1'b0;
    model_reset();
    #2;
    check_regs("async_rst");
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    applyStimulus("post_rst", 0,0,0, 4'd14, 0,1,1,0, 4'h5, 2'b00, 4'h5, 4'h5);

    // Randomized run: results carry consistent Z/N flags, codes biased legal
    for (int i = 0; i < 400; i++) begin
      r_res  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      r_cond = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 8)];
      applyStimulus("rand",
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 5) != 0), r_cond,
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    r_res, {r_res[3], (r_res == 4'h0)}, 4'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

  // Quiet input values used while reset is held
  task automatic applyDefaults();
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    valid_i      = 1'b0;
    cond_i       = 4'd0;
    flag_write_i = 1'b0;
    reg_write_i  = 1'b0;
    mem_write_i  = 1'b0;
    branch_i     = 1'b0;
    alu_result_i = 4'h0;
    alu_flags_i  = 2'b00;
    write_data_i = 4'h0;
    rd_i         = 4'h0;
  endtask

endmodule
